// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: sequences one AES core through key expansion and back-to-back
// block processing, with FIFO buffering on the block input and the result output.
module aes_stream_ctrl #(
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [255:0]     cfg_key,
  input  logic             cfg_keylen,
  input  logic             cfg_encdec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err,
  output logic [15:0]      blk_count,
  output logic             core_init,
  output logic             core_next,
  output logic             core_encdec,
  output logic             core_keylen,
  output logic [255:0]     core_key,
  output logic [127:0]     core_block,
  input  logic             core_ready,
  input  logic             core_result_valid,
  input  logic [127:0]     core_result
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int ENT_W  = 128 + TAG_W;

  typedef enum logic [2:0] {
    IDLE, KEY_INIT, KEY_DROP, KEY_WAIT, KEYED, BLK_START, BLK_DROP, BLK_WAIT
  } state_t;

  state_t state_reg, state_next;

  logic             run_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_hit, timed;
  logic             err_set;
  logic             cfg_fire, in_push, in_pop, out_push, out_pop;
  logic             reserved_reg;
  logic [TAG_W-1:0] tag_pend_reg;

  logic [ENT_W-1:0] in_mem [IN_DEPTH];
  logic [IN_AW:0]   in_wr_ptr, in_rd_ptr;
  logic             in_empty, in_full;
  logic [ENT_W-1:0] in_entry;

  logic [ENT_W-1:0] out_mem [OUT_DEPTH];
  logic [OUT_AW:0]  out_wr_ptr, out_rd_ptr;
  logic [OUT_AW:0]  out_count;
  logic [OUT_AW+1:0] occupied;
  logic             credit_ok;
  logic [ENT_W-1:0] out_entry;

  // Handshake readies stay low while reset is held so every output reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  // ---------------- input FIFO ----------------
  assign in_empty = (in_wr_ptr == in_rd_ptr);
  assign in_full  = (in_wr_ptr[IN_AW] != in_rd_ptr[IN_AW]) &&
                    (in_wr_ptr[IN_AW-1:0] == in_rd_ptr[IN_AW-1:0]);
  assign in_ready = run_reg && !in_full;
  assign in_push  = in_valid && in_ready;
  assign in_entry = in_mem[in_rd_ptr[IN_AW-1:0]];

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr[IN_AW-1:0]] <= {in_tag, in_block};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
    end
  end

  // ---------------- output FIFO (first-word-fall-through) ----------------
  assign out_count = out_wr_ptr - out_rd_ptr;
  assign out_valid = (out_wr_ptr != out_rd_ptr);
  assign out_pop   = out_valid && out_ready;
  assign out_entry = out_mem[out_rd_ptr[OUT_AW-1:0]];
  assign out_block = out_valid ? out_entry[127:0] : 128'h0;
  assign out_tag   = out_valid ? out_entry[ENT_W-1:128] : '0;

  // A slot is reserved for the in-flight block so the result push never stalls.
  assign occupied  = (OUT_AW+2)'(out_count) + (OUT_AW+2)'(reserved_reg);
  assign credit_ok = occupied < (OUT_AW+2)'(OUT_DEPTH);

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr[OUT_AW-1:0]] <= {tag_pend_reg, core_result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
    end
  end

  // ---------------- sequencer ----------------
  assign cfg_ready = run_reg && ((state_reg == IDLE) || ((state_reg == KEYED) && in_empty));
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign timed     = (state_reg == KEY_DROP) || (state_reg == KEY_WAIT) ||
                     (state_reg == BLK_DROP) || (state_reg == BLK_WAIT);
  assign tmo_hit   = timed && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
  assign busy      = ((state_reg != IDLE) && (state_reg != KEYED)) || !in_empty;

  always_comb begin
    state_next = state_reg;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    err_set    = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_fire) state_next = KEY_INIT;
      end
      KEY_INIT: begin
        core_init  = 1'b1;
        state_next = KEY_DROP;
      end
      KEY_DROP: begin
        if (!core_ready)  state_next = KEY_WAIT;
        else if (tmo_hit) begin err_set = 1'b1; state_next = IDLE; end
      end
      KEY_WAIT: begin
        if (core_ready)   state_next = KEYED;
        else if (tmo_hit) begin err_set = 1'b1; state_next = IDLE; end
      end
      KEYED: begin
        if (cfg_fire) state_next = KEY_INIT;
        else if (!in_empty && credit_ok) begin
          in_pop     = 1'b1;
          state_next = BLK_START;
        end
      end
      BLK_START: begin
        core_next  = 1'b1;
        state_next = BLK_DROP;
      end
      BLK_DROP: begin
        if (!core_result_valid) state_next = BLK_WAIT;
        else if (tmo_hit)       begin err_set = 1'b1; state_next = IDLE; end
      end
      BLK_WAIT: begin
        if (core_result_valid) begin
          out_push   = 1'b1;
          state_next = KEYED;
        end else if (tmo_hit) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) tmo_cnt_reg <= '0;
      else if (timed)              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Key settings are held on the core between configs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key    <= '0;
      core_keylen <= 1'b0;
      core_encdec <= 1'b0;
    end else if (cfg_fire) begin
      core_key    <= cfg_key;
      core_keylen <= cfg_keylen;
      core_encdec <= cfg_encdec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_block   <= '0;
      tag_pend_reg <= '0;
      reserved_reg <= 1'b0;
    end else begin
      if (in_pop) begin
        core_block   <= in_entry[127:0];
        tag_pend_reg <= in_entry[ENT_W-1:128];
        reserved_reg <= 1'b1;
      end else if (out_push || err_set) begin
        reserved_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      blk_count <= '0;
    end else begin
      if (err_set)  err       <= 1'b1;
      if (out_push) blk_count <= blk_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: drives aes_stream_ctrl against a behavioural AES-core stub and
// checks results, ordering, credit backpressure, re-key draining, timeout and reset.
module tb_aes_stream_ctrl;
  localparam int TAG_W = 4;
  localparam int TMO   = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_valid = 0, cfg_keylen = 0, cfg_encdec = 0;
  logic [255:0]     cfg_key = '0;
  logic             in_valid = 0, out_ready = 0;
  logic [127:0]     in_block = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             cfg_ready, in_ready, out_valid, busy, err;
  logic [127:0]     out_block, core_block, core_result;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      blk_count;
  logic             core_init, core_next, core_encdec, core_keylen;
  logic [255:0]     core_key;
  logic             core_ready, core_result_valid;

  aes_stream_ctrl #(.IN_DEPTH(4), .OUT_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_keylen(cfg_keylen), .cfg_encdec(cfg_encdec),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_tag(out_tag),
    .busy(busy), .err(err), .blk_count(blk_count),
    .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
    .core_keylen(core_keylen), .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_result_valid(core_result_valid), .core_result(core_result)
  );

  int checks = 0;
  int errors = 0;

  // Stand-in cipher: any key/mode/length change gives a different result.
  function automatic logic [127:0] xform(input logic [255:0] k, input logic kl,
                                         input logic ed, input logic [127:0] b);
    logic [127:0] kk;
    kk = k[255:128] ^ (kl ? k[127:0] : 128'h0);
    return ed ? (b ^ kk) : ~(b ^ {kk[63:0], kk[127:64]});
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- AES core stub ----------------
  logic         stub_hang = 1'b0;
  logic         stub_rdy, stub_blk, stub_kl;
  logic [255:0] stub_key;
  int           stub_cnt;
  assign core_ready = stub_rdy && !stub_hang;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_rdy <= 1'b1; core_result_valid <= 1'b0; core_result <= '0;
      stub_cnt <= 0; stub_blk <= 1'b0; stub_key <= '0; stub_kl <= 1'b0;
    end else if (core_init) begin
      stub_rdy <= 1'b0; stub_cnt <= 4; stub_blk <= 1'b0;
      stub_key <= core_key; stub_kl <= core_keylen;
    end else if (core_next) begin
      stub_rdy <= 1'b0; core_result_valid <= 1'b0; stub_blk <= 1'b1;
      stub_cnt <= $urandom_range(2, 7);
      core_result <= xform(stub_key, stub_kl, core_encdec, core_block);
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_rdy <= 1'b1;
        if (stub_blk) core_result_valid <= 1'b1;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  logic [255:0]     m_key = '0;
  logic             m_kl = 0, m_ed = 0;
  logic [127:0]     exp_blk[$];
  logic [TAG_W-1:0] exp_tag[$];
  int n_accepted = 0, next_pulses = 0, init_pulses = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_valid && cfg_ready) begin
        m_key = cfg_key; m_kl = cfg_keylen; m_ed = cfg_encdec;
      end
      if (in_valid && in_ready) begin
        exp_blk.push_back(xform(m_key, m_kl, m_ed, in_block));
        exp_tag.push_back(in_tag);
        n_accepted++;
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_blk.size() != 0) else begin
          errors++;
          $error("FAIL out_extra: observed tag %h block %h expected no result", out_tag, out_block);
        end
        if (exp_blk.size() != 0) begin
          check("out_block", out_block, exp_blk.pop_front());
          check("out_tag", out_tag, exp_tag.pop_front());
        end
      end
      if (core_init || core_next) begin
        checks++;
        assert (!(core_init && core_next) && !prev_pulse) else begin
          errors++;
          $error("FAIL pulse_spacing: observed init=%b next=%b prev=%b expected isolated pulse",
                 core_init, core_next, prev_pulse);
        end
      end
      if (core_next) next_pulses++;
      if (core_init) init_pulses++;
      prev_pulse = core_init || core_next;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 1'b0;

  task automatic step();
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_cfg(input logic [255:0] k, input logic kl, input logic ed, output bit ok);
    cfg_valid = 1; cfg_key = k; cfg_keylen = kl; cfg_encdec = ed; ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); ok = cfg_ready; step();
    end
    cfg_valid = 0;
  endtask

  task automatic push(input logic [127:0] b, input logic [TAG_W-1:0] t, output bit ok);
    in_valid = 1; in_block = b; in_tag = t; ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); ok = in_ready; step();
    end
    in_valid = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); ok = (exp_blk.size() == 0) && !busy && !out_valid; step();
    end
  endtask

  task automatic clear_model();
    exp_blk.delete(); exp_tag.delete();
    n_accepted = 0; next_pulses = 0; init_pulses = 0;
    m_key = '0; m_kl = 0; m_ed = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    bit ok;
    int cyc;
    int base_next, base_init;
    logic [255:0] rk;

    // Reset state
    rst_n = 0; step(); step(); rst_n = 1; clear_model(); step(); step();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_blk_count", blk_count, 0);

    // Single blocks: AES-128 enc, AES-128 dec, AES-256 enc
    out_ready = 1;
    do_cfg(K128, 0, 1, ok); check("cfg128e_accept", ok, 1);
    check("core_key_held", core_key, K128);
    push(PT, 4'd5, ok); check("push_t1", ok, 1);
    wait_idle(ok); check("drain_t1", ok, 1);
    do_cfg(K128, 0, 0, ok); check("cfg128d_accept", ok, 1);
    push(CT, 4'd6, ok); check("push_t2", ok, 1);
    wait_idle(ok); check("drain_t2", ok, 1);
    check("blk_count_t2", blk_count, 16'(n_accepted));
    do_cfg(K256, 1, 1, ok); check("cfg256e_accept", ok, 1);
    check("core_keylen_held", core_keylen, 1);
    push(PT, 4'd7, ok); check("push_t3", ok, 1);
    wait_idle(ok); check("drain_t3", ok, 1);

    // Backpressure: 8 blocks fit (4 results + 4 queued), exactly 4 started
    out_ready = 0;
    base_next = next_pulses;
    for (int i = 0; i < 8; i++) begin
      push(128'($urandom) << 64 | 128'($urandom), 4'(i), ok);
      check("bp_push", ok, 1);
    end
    repeat (100) step();
    check("bp_in_ready", in_ready, 0);
    check("bp_next_count", next_pulses - base_next, 4);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1;
    wait_idle(ok); check("bp_drain", ok, 1);

    // Re-key with two blocks queued: old key finishes first
    push(PT ^ 128'h1, 4'd8, ok); check("rk_push0", ok, 1);
    push(PT ^ 128'h2, 4'd9, ok); check("rk_push1", ok, 1);
    check("rk_cfg_blocked", cfg_ready, 0);
    base_init = init_pulses;
    do_cfg(K128, 0, 1, ok); check("rk_accept", ok, 1);
    check("rk_blk_count", blk_count, 16'(n_accepted));
    repeat (20) step();
    check("rk_init_pulses", init_pulses - base_init, 1);
    for (int i = 0; i < 3; i++) begin
      push(PT + 128'(i), 4'(10 + i), ok); check("rk_push_new", ok, 1);
    end
    wait_idle(ok); check("rk_drain", ok, 1);

    // Randomized rounds with random keys and random output backpressure
    rand_ready = 1;
    for (int r = 0; r < 3; r++) begin
      rk = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
            32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      do_cfg(rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      check("rnd_cfg", ok, 1);
      for (int i = 0; i < 12; i++) begin
        push({32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
             4'($urandom_range(0, 15)), ok);
        check("rnd_push", ok, 1);
        repeat ($urandom_range(0, 3)) step();
      end
      wait_idle(ok); check("rnd_drain", ok, 1);
    end
    rand_ready = 0; out_ready = 1;
    check("rnd_blk_count", blk_count, 16'(n_accepted));
    check("err_still_clear", err, 0);

    // Timeout: core never becomes ready again
    stub_hang = 1;
    do_cfg(K256, 1, 0, ok); check("tmo_cfg", ok, 1);
    cyc = 0;
    while (!err && cyc < TMO + 50) begin step(); cyc++; end
    checks++;
    assert (err && cyc >= TMO && cyc <= TMO + 4) else begin
      errors++;
      $error("FAIL tmo_cycles: observed err=%b after %0d cycles expected err=1 after %0d..%0d",
             err, cyc, TMO, TMO + 4);
    end
    check("tmo_idle_busy", busy, 0);
    check("tmo_idle_cfg_ready", cfg_ready, 1);

    // Mid-operation reset: all outputs drop in the same cycle
    do_cfg(K128, 0, 1, ok); check("mid_cfg", ok, 1);
    push(PT, 4'd3, ok); check("mid_push", ok, 1);
    repeat (3) step();
    check("mid_busy", busy, 1);
    #2 rst_n = 0; #1;
    check("mid_rst_ctl", {cfg_ready, in_ready, out_valid, busy, err,
                          core_init, core_next, core_encdec, core_keylen}, 0);
    check("mid_rst_count", blk_count, 0);
    check("mid_rst_key", core_key, 0);
    check("mid_rst_data", {core_block, out_block, out_tag}, 0);
    step(); stub_hang = 0; rst_n = 1; clear_model(); step();

    // Recovery after reset
    do_cfg(K128, 0, 1, ok); check("rec_cfg", ok, 1);
    push(PT, 4'd5, ok); check("rec_push", ok, 1);
    wait_idle(ok); check("rec_drain", ok, 1);
    check("rec_blk_count", blk_count, 1);
    check("rec_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
